// File: rtl/mpsoc_ahb3_ext_sram_slave.sv
// -----------------------------------------------------------------------------
// mpsoc_ahb3_ext_sram_slave
//
// AHB3-Lite slave that terminates one tile's external AHB master port with a
// byte-addressable on-chip SRAM model. It supports configurable wait states
// and returns a two-cycle ERROR response for illegal accesses (oversize,
// misaligned, or out-of-range).
//
// Parameters:
//   PLEN        address width
//   XLEN        data width (32 or 64)
//   MEM_SIZE    memory size in bytes (power of two, multiple of XLEN/8)
//   WAIT_STATES extra data-phase cycles per OKAY transfer (0..15)
//
// Ports:
//   clk                  clock
//   rst                  asynchronous reset, active-low
//   ahb3_ext_hsel_i      slave select
//   ahb3_ext_haddr_i     byte address (address phase)
//   ahb3_ext_hwdata_i    write data (data phase)
//   ahb3_ext_hwrite_i    1 = write
//   ahb3_ext_hsize_i     transfer size (log2 bytes)
//   ahb3_ext_hburst_i    burst type (ignored)
//   ahb3_ext_hprot_i     protection (ignored)
//   ahb3_ext_htrans_i    IDLE/BUSY/NONSEQ/SEQ
//   ahb3_ext_hmastlock_i lock (ignored)
//   ahb3_ext_hrdata_o    read data, full word, valid in the read data phase
//   ahb3_ext_hready_o    transfer done / slave ready (also the bus HREADY)
//   ahb3_ext_hresp_o     0 = OKAY, 1 = ERROR
// -----------------------------------------------------------------------------
module mpsoc_ahb3_ext_sram_slave #(
    parameter int PLEN        = 32,
    parameter int XLEN        = 32,
    parameter int MEM_SIZE    = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ahb3_ext_hsel_i,
    input  logic [PLEN-1:0] ahb3_ext_haddr_i,
    input  logic [XLEN-1:0] ahb3_ext_hwdata_i,
    input  logic            ahb3_ext_hwrite_i,
    input  logic [2:0]      ahb3_ext_hsize_i,
    input  logic [2:0]      ahb3_ext_hburst_i,
    input  logic [3:0]      ahb3_ext_hprot_i,
    input  logic [1:0]      ahb3_ext_htrans_i,
    input  logic            ahb3_ext_hmastlock_i,
    output logic [XLEN-1:0] ahb3_ext_hrdata_o,
    output logic            ahb3_ext_hready_o,
    output logic            ahb3_ext_hresp_o
);

    localparam int BYTES = XLEN / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int WORDS = MEM_SIZE / BYTES;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    // Byte lanes touched by a transfer of 2^size bytes starting at lane off.
    function automatic logic [BYTES-1:0] lane_mask(input logic [LB-1:0] off,
                                                   input logic [2:0]    size);
        logic [BYTES-1:0] m;
        m = {BYTES{1'b0}};
        for (int b = 0; b < BYTES; b++) begin
            if ((b >= int'(off)) && (b < (int'(off) + int'(32'd1 << size)))) begin
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

    // Size fits the bus, address is naturally aligned, and it lies inside
    // the memory (full-width compare so high address bits cannot alias).
    function automatic logic is_legal(input logic [PLEN-1:0] addr,
                                      input logic [2:0]      size);
        logic [PLEN-1:0] low_mask;
        low_mask = ~({PLEN{1'b1}} << size);
        return (size <= 3'(LB)) &&
               ((addr & low_mask) == {PLEN{1'b0}}) &&
               (addr < PLEN'(MEM_SIZE));
    endfunction

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_cnt;
    logic [3:0]        w_next_cnt;
    logic [AW-1:0]     r_word;
    logic [BYTES-1:0]  r_be;
    logic              r_write;
    logic              r_hready;
    logic              r_hresp;
    logic [XLEN-1:0]   r_hrdata;
    logic [XLEN-1:0]   r_mem [WORDS];

    logic              w_accept;
    logic              w_legal;
    logic              w_commit;
    logic [XLEN-1:0]   w_bit_mask;
    logic [XLEN-1:0]   w_wr_merged;
    logic [AW-1:0]     w_next_word;
    logic              w_next_is_read;
    logic [XLEN-1:0]   w_rd_data;
    logic              w_unused;

    assign w_unused = ^{ahb3_ext_hburst_i, ahb3_ext_hprot_i,
                        ahb3_ext_hmastlock_i, ahb3_ext_htrans_i[0]};

    assign w_accept = ahb3_ext_hsel_i & ahb3_ext_htrans_i[1] & r_hready;
    assign w_legal  = is_legal(ahb3_ext_haddr_i, ahb3_ext_hsize_i);
    assign w_commit = (r_state == S_DATA) & r_write;

    // Next-state and wait counter. The counter is loaded with the wait count
    // at accept and the FSM leaves WAIT on the cycle it would reach zero, so
    // hready stays low for exactly WAIT_STATES cycles.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (w_accept) begin
                    if (!w_legal) begin
                        w_next_state = S_ERR1;
                    end else if (WS != 4'd0) begin
                        w_next_state = S_WAIT;
                        w_next_cnt   = WS;
                    end else begin
                        w_next_state = S_DATA;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT: begin
                w_next_cnt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_next_state = S_DATA;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_ERR1: begin
                w_next_state = S_ERR2;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Expand the latched byte enables into a bit mask and merge the write.
    always_comb begin
        w_bit_mask = {XLEN{1'b0}};
        for (int b = 0; b < BYTES; b++) begin
            w_bit_mask[8*b +: 8] = {8{r_be[b]}};
        end
        w_wr_merged = (r_mem[r_word] & ~w_bit_mask) | (ahb3_ext_hwdata_i & w_bit_mask);
    end

    // Word that the upcoming DATA cycle reads. A write committing on the same
    // edge to the same word is forwarded so the read sees the new data.
    always_comb begin
        if (r_state == S_WAIT) begin
            w_next_word    = r_word;
            w_next_is_read = ~r_write;
        end else begin
            w_next_word    = ahb3_ext_haddr_i[LB +: AW];
            w_next_is_read = ~ahb3_ext_hwrite_i;
        end
        if (w_commit && (r_word == w_next_word)) begin
            w_rd_data = w_wr_merged;
        end else begin
            w_rd_data = r_mem[w_next_word];
        end
    end

    // State, latched address-phase info and registered bus outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_word   <= {AW{1'b0}};
            r_be     <= {BYTES{1'b0}};
            r_write  <= 1'b0;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
            r_hrdata <= {XLEN{1'b0}};
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_word  <= ahb3_ext_haddr_i[LB +: AW];
                r_be    <= lane_mask(ahb3_ext_haddr_i[LB-1:0], ahb3_ext_hsize_i);
                r_write <= ahb3_ext_hwrite_i & w_legal;
            end
            r_hready <= ~((w_next_state == S_WAIT) || (w_next_state == S_ERR1));
            r_hresp  <= (w_next_state == S_ERR1) || (w_next_state == S_ERR2);
            if ((w_next_state == S_DATA) && w_next_is_read) begin
                r_hrdata <= w_rd_data;
            end
        end
    end

    // SRAM array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_word] <= w_wr_merged;
        end
    end

    assign ahb3_ext_hrdata_o = r_hrdata;
    assign ahb3_ext_hready_o = r_hready;
    assign ahb3_ext_hresp_o  = r_hresp;

endmodule

// File: tb/tb_mpsoc_ahb3_ext_sram_slave.sv
// -----------------------------------------------------------------------------
// Testbench for mpsoc_ahb3_ext_sram_slave. Two instances are exercised: one
// with zero wait states and one with three. A byte-array reference model
// produces the expected response of every accepted transfer, which is queued;
// a monitor pops and compares whenever a data phase completes.
// -----------------------------------------------------------------------------
module tb_mpsoc_ahb3_ext_sram_slave;

    localparam int MEMSZ = 4096;

    typedef struct {
        bit          rd;
        bit          resp;
        int          waits;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        hsel   [2];
    logic [31:0] haddr  [2];
    logic [31:0] hwdata [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    logic [2:0]  hburst [2];
    logic [3:0]  hprot  [2];
    logic [1:0]  htrans [2];
    logic        hlock  [2];
    logic [31:0] hrdata [2];
    logic        hready [2];
    logic        hresp  [2];

    int          tests = 0;
    int          fails = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    bit          indp   [2];
    int          lowc   [2];
    bit          errlow [2];
    bit          done = 1'b0;
    bit          checked = 1'b0;
    int          drv_to = 0;
    logic [7:0]  mdl [2][MEMSZ];

    always #5 clk = ~clk;

    mpsoc_ahb3_ext_sram_slave #(.PLEN(32), .XLEN(32), .MEM_SIZE(MEMSZ), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst_n),
        .ahb3_ext_hsel_i(hsel[0]), .ahb3_ext_haddr_i(haddr[0]), .ahb3_ext_hwdata_i(hwdata[0]),
        .ahb3_ext_hwrite_i(hwrite[0]), .ahb3_ext_hsize_i(hsize[0]), .ahb3_ext_hburst_i(hburst[0]),
        .ahb3_ext_hprot_i(hprot[0]), .ahb3_ext_htrans_i(htrans[0]), .ahb3_ext_hmastlock_i(hlock[0]),
        .ahb3_ext_hrdata_o(hrdata[0]), .ahb3_ext_hready_o(hready[0]), .ahb3_ext_hresp_o(hresp[0])
    );

    mpsoc_ahb3_ext_sram_slave #(.PLEN(32), .XLEN(32), .MEM_SIZE(MEMSZ), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst_n),
        .ahb3_ext_hsel_i(hsel[1]), .ahb3_ext_haddr_i(haddr[1]), .ahb3_ext_hwdata_i(hwdata[1]),
        .ahb3_ext_hwrite_i(hwrite[1]), .ahb3_ext_hsize_i(hsize[1]), .ahb3_ext_hburst_i(hburst[1]),
        .ahb3_ext_hprot_i(hprot[1]), .ahb3_ext_htrans_i(htrans[1]), .ahb3_ext_hmastlock_i(hlock[1]),
        .ahb3_ext_hrdata_o(hrdata[1]), .ahb3_ext_hready_o(hready[1]), .ahb3_ext_hresp_o(hresp[1])
    );

    // ---------------- reference model ----------------
    function automatic exp_t model(input int d, input bit wr, input logic [31:0] a,
                                   input logic [2:0] sz, input logic [31:0] wd, input bit commit);
        exp_t        e;
        bit          legal;
        int          nbytes;
        int          lane;
        logic [31:0] base;
        nbytes = 1 << sz;
        legal  = (sz <= 3'd2) && ((a % nbytes) == 0) && (a < MEMSZ);
        e.rd    = !wr;
        e.resp  = !legal;
        e.waits = legal ? ((d == 0) ? 0 : 3) : 1;
        e.data  = 32'h0;
        if (legal && wr && commit) begin
            lane = int'(a % 4);
            for (int b = 0; b < nbytes; b++) begin
                mdl[d][a + b] = wd[8*(lane + b) +: 8];
            end
        end
        if (legal && !wr) begin
            base   = a - (a % 4);
            e.data = {mdl[d][base + 3], mdl[d][base + 2], mdl[d][base + 1], mdl[d][base]};
        end
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd, input bit commit);
        exp_t e;
        bit   ok;
        int   n;
        hsel[d]   = 1'b1;
        haddr[d]  = a;
        hwrite[d] = wr;
        hsize[d]  = sz;
        htrans[d] = 2'b10;
        hburst[d] = 3'($urandom_range(0, 7));
        hprot[d]  = 4'($urandom_range(0, 15));
        hlock[d]  = 1'($urandom_range(0, 1));
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 64) begin
            @(negedge clk);
            ok = hready[d];
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            drv_to++;
        end else begin
            e = model(d, wr, a, sz, wd, commit);
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
            hwdata[d] = wr ? wd : $urandom;
        end
    endtask

    task automatic beat(input int d, input logic [1:0] tr);
        hsel[d]   = 1'b1;
        htrans[d] = tr;
        haddr[d]  = $urandom;
        hwrite[d] = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int n);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, d, act, exp, $time);
        end
    endtask

    task automatic mon_step(input int d);
        exp_t e;
        bit   acc;
        int   qn;
        if (!rst_n) begin
            chk("rst_hready", d, 32'(hready[d]), 32'd1);
            chk("rst_hresp",  d, 32'(hresp[d]),  32'd0);
            chk("rst_hrdata", d, hrdata[d],      32'd0);
            indp[d]   = 1'b0;
            lowc[d]   = 0;
            errlow[d] = 1'b0;
        end else begin
            acc = hsel[d] & htrans[d][1] & hready[d];
            if (indp[d]) begin
                if (!hready[d]) begin
                    lowc[d]++;
                    if (hresp[d]) errlow[d] = 1'b1;
                    if (lowc[d] > 40) begin
                        tests++;
                        fails++;
                        $display("FAIL stall dut%0d: got %0d low cycles expected at most 15", d, lowc[d]);
                        indp[d] = 1'b0;
                        lowc[d] = 0;
                    end
                end else begin
                    qn = (d == 0) ? q0.size() : q1.size();
                    if (qn == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done dut%0d: got completion expected none", d);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk("wait_cycles", d, 32'(lowc[d]), 32'(e.waits));
                        chk("hresp",       d, 32'(hresp[d]), 32'(e.resp));
                        chk("err_first",   d, 32'(errlow[d]), 32'(e.resp));
                        if (e.rd && !e.resp) chk("hrdata", d, hrdata[d], e.data);
                    end
                    lowc[d]   = 0;
                    errlow[d] = 1'b0;
                    indp[d]   = acc;
                end
            end else begin
                chk("idle_hready", d, 32'(hready[d]), 32'd1);
                chk("idle_hresp",  d, 32'(hresp[d]),  32'd0);
                indp[d] = acc;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon_step(d);
        if (done && !checked) begin
            chk("q_drained", 0, q0.size(), 32'd0);
            chk("q_drained", 1, q1.size(), 32'd0);
            chk("drv_timeout", 0, 32'(drv_to), 32'd0);
            checked = 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        int          r;
        for (int d = 0; d < 2; d++) begin
            hsel[d] = 1'b0; haddr[d] = 32'h0; hwdata[d] = 32'h0; hwrite[d] = 1'b0;
            hsize[d] = 3'd0; hburst[d] = 3'd0; hprot[d] = 4'd0; htrans[d] = 2'b00; hlock[d] = 1'b0;
            indp[d] = 1'b0; lowc[d] = 0; errlow[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int d = 0; d < 2; d++) begin
            // prefill low region and the last word so every read is defined
            for (int w = 0; w < 64; w++) xfer(d, 1'b1, 32'(w * 4), 3'd2, $urandom, 1'b1);
            xfer(d, 1'b1, 32'hFFC, 3'd2, $urandom, 1'b1);

            xfer(d, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b1);
            xfer(d, 1'b0, 32'h10, 3'd2, 32'h0, 1'b1);
            xfer(d, 1'b1, 32'h10, 3'd2, 32'h11223344, 1'b1);
            xfer(d, 1'b1, 32'h13, 3'd0, 32'hAA000000, 1'b1);
            xfer(d, 1'b0, 32'h10, 3'd2, 32'h0, 1'b1);
            beat(d, 2'b01);
            beat(d, 2'b00);
            xfer(d, 1'b0, 32'h10, 3'd2, 32'h0, 1'b1);
            xfer(d, 1'b0, 32'h1000, 3'd2, 32'h0, 1'b1);
            xfer(d, 1'b0, 32'h01, 3'd1, 32'h0, 1'b1);
            xfer(d, 1'b1, 32'h20, 3'd2, 32'hCAFEF00D, 1'b1);
            xfer(d, 1'b0, 32'h00, 3'd2, 32'h0, 1'b1);
            xfer(d, 1'b0, 32'h20, 3'd2, 32'h0, 1'b1);
            for (int k = 0; k < 4; k++) xfer(d, 1'b0, 32'(32'h40 + k * 4), 3'd2, 32'h0, 1'b1);

            for (int i = 0; i < 150; i++) begin
                r  = int'($urandom_range(0, 9));
                sz = (r == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                if (r == 1)      a = 32'h1000 + 32'($urandom_range(0, 255));
                else if (r == 2) a = 32'hFFC + 32'($urandom_range(0, 3));
                else if (r == 3) a = $urandom | 32'h8000_0000;
                else             a = 32'($urandom_range(0, 255));
                xfer(d, 1'($urandom_range(0, 1)), a, sz, $urandom, 1'b1);
                if ($urandom_range(0, 4) == 0) beat(d, 2'($urandom_range(0, 1)));
            end
            idle(d, 10);
        end

        // reset during the second wait cycle of a write discards the write
        xfer(1, 1'b1, 32'h30, 3'd2, 32'h55AA55AA, 1'b0);
        @(posedge clk);
        #1;
        hsel[1]   = 1'b0;
        htrans[1] = 2'b00;
        rst_n     = 1'b0;
        q1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        xfer(1, 1'b0, 32'h30, 3'd2, 32'h0, 1'b1);
        xfer(1, 1'b0, 32'h34, 3'd2, 32'h0, 1'b1);
        idle(1, 10);
        idle(0, 2);

        done = 1'b1;
        repeat (3) @(posedge clk);
        if (!checked) begin
            $display("FAIL final_check: monitor did not run the drain check");
            fails++;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
